uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority voting, start-bit validation, parity and framing error detection.
- Valid/ready output handshake with overrun reporting; sits between the board RX pin and the command/packet parser.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate.
- DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- BPS_CNT (local), CLK_FREQ/UART_BPS, clocks per bit; must be >= 8. Counter width = $clog2(BPS_CNT).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- uart_rxd  in  1  asynchronous serial input, idle high.
- uart_data  out  DATA_BITS  received word, held stable while uart_valid=1.
- uart_valid  out  1  word available.
- uart_ready  in  1  consumer accepts; transfer occurs when valid && ready.
- parity_err  out  1  sideband for uart_data: parity mismatch; forced 0 when PARITY=0.
- frame_err  out  1  sideband for uart_data: any stop bit sampled 0.
- overrun  out  1  one-cycle pulse: a frame completed while uart_valid=1 and uart_ready=0.

Behaviour:
- Reset (synchronous, sys_rst=1): state=IDLE, counters=0, synchroniser FFs=1. Outputs: uart_data=0, uart_valid=0, parity_err=0, frame_err=0, overrun=0.
- Input synchroniser: 2-FF synchroniser on uart_rxd, then a third FF for edge detection. A falling edge is synced-prev=1 && synced=0.
- Bit timing:
  - clk_cnt counts 0..BPS_CNT-1 and wraps; it is cleared on entry to START.
  - Sample points are clk_cnt = MID-1, MID, MID+1, where MID = BPS_CNT/2.
  - Bit value is the majority of the 3 samples and is resolved at MID+1.
- State machine:
  - IDLE: on falling edge -> START.
  - START: at MID+1, voted 1 (glitch) -> IDLE with no output; voted 0 -> continue; at clk_cnt wrap -> DATA.
  - DATA: shift the voted bit into bit index bit_cnt, LSB first. After DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare the voted bit with the computed parity (XOR of data; odd mode inverts) and record the mismatch.
  - STOP: one or two stop bits. A voted 0 in any stop bit sets frame_err_int. At MID+1 of the last stop bit, commit the frame -> IDLE immediately (do not wait out the bit), so back-to-back frames are caught.
- Commit: the frame commits at the cycle of the last stop MID+1 vote.
  - If the output is empty, or being consumed in that same cycle (valid && ready): next cycle uart_data, parity_err and frame_err load and uart_valid=1. Latency = 1 clock after the final vote.
  - If valid=1 and ready=0: keep the old word, drop the new one, pulse overrun for 1 cycle.
- Handshake: uart_valid stays high until valid && ready. Without a new commit, valid clears the next cycle. Data and error flags are constant while valid.
- Frames with errors are still delivered; the consumer decides what to do with them.
- Reset mid-frame: discard the partial frame, return to IDLE, drop any pending valid.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output break_det (1 bit, reset 0).
  - A frame whose data bits are all 0, parity bit 0 (if present) and first stop bit 0 is a break. It is not delivered to uart_data and does not pulse overrun.
  - break_det goes high the cycle after the stop vote and stays high until the synchronised line has been 1 for one full BPS_CNT period. After that the receiver re-arms in IDLE.
- Undefined: no break_det port; a break is delivered as data 0 with frame_err=1.

Test Plan:
(All cases use CLK_FREQ=1000000 and UART_BPS=100000, so BPS_CNT=10, unless stated.)
- 8N1, send 0xA5 with uart_ready=1 -> uart_valid pulses 1 cycle, uart_data=0xA5, parity_err=0, frame_err=0, commit 1 clock after stop MID+1.
- PARITY=2, DATA_BITS=7, send 0x41 with parity bit forced 1 (correct bit is 0) -> uart_data=0x41, parity_err=1. Then send with correct parity 0 -> parity_err=0.
- STOP_BITS=2, send 0x3C with second stop bit driven 0 -> uart_data=0x3C, frame_err=1.
- Drive a 3-cycle low glitch on idle line -> no uart_valid, FSM back in IDLE. Then a valid frame 0x5A is received correctly.
- uart_ready=0, send 0x11 then 0x22 back-to-back -> uart_data holds 0x11, overrun pulses once at the second commit. Raise ready -> 0x11 transfers, no 0x22 appears.
- Assert sys_rst for 1 cycle in the middle of bit 4 of frame 0xFF -> no output. Next frame 0x81 is received correctly. With UART_RX_BREAK_DET_EN, a 12-bit-long low -> break_det=1, no uart_valid.

Source files
------------

// File: rtl/uart_rx_param.sv
// Purpose : parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
//           with 2-FF input synchroniser, 3-sample majority vote and start-bit glitch rejection.
// Latency : word is presented 1 clock after the majority vote of the last stop bit.
// Backpressure: valid/ready output; a frame completing while valid=1 and ready=0 is dropped and
//           overrun pulses for one cycle (the held word is kept).
// Optional: define UART_RX_BREAK_DET_EN to add break_det (break frames are then not delivered).
// Ports   : sys_clk/sys_rst (sync, active-high), uart_rxd (async serial in, idle high),
//           uart_data/uart_valid/uart_ready (output handshake), parity_err/frame_err (sideband
//           of uart_data), overrun (pulse), break_det (only with UART_RX_BREAK_DET_EN).
module uart_rx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 uart_valid,
    input  logic                 uart_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                 break_det
`endif
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] SMP_A   = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_B   = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] SMP_C   = CNT_W'(BPS_CNT / 2 + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
    localparam logic [2:0] ST_BREAK  = 3'd5;
`endif

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 operr_q, operr_d;
    logic                 oferr_q, oferr_d;
    logic                 ovr_q, ovr_d;
    logic                 fall, vote, at_vote, wrap, exp_par, commit;
`ifdef UART_RX_BREAK_DET_EN
    logic                 parbit_q, parbit_d;
    logic                 brk_q, brk_d;
    logic                 is_break;
`endif

    assign fall    = rx_prev_q & ~rx_sync_q;
    // Majority of the two stored samples and the live third sample.
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
    assign at_vote = (cnt_q == SMP_C);
    assign wrap    = (cnt_q == CNT_MAX);
    assign exp_par = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

`ifdef UART_RX_BREAK_DET_EN
    // Evaluated at the first stop bit vote: all-zero data, zero parity, zero stop.
    assign is_break = (bit_q == 4'd0) && !vote && (shift_q == '0) && ((PARITY == 0) || !parbit_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = valid_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        ovr_d   = 1'b0;
        commit  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        parbit_d = parbit_q;
        brk_d    = brk_q;
`endif

        if (cnt_q == SMP_A) samp_d[0] = rx_sync_q;
        if (cnt_q == SMP_B) samp_d[1] = rx_sync_q;
        if (state_q != ST_IDLE) cnt_d = wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    state_d = ST_IDLE;   // glitch, not a real start bit
                end else if (wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                // Shift in from the top: after DATA_BITS shifts the first bit sits at the LSB.
                if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (at_vote) begin
                    perr_d = (vote != exp_par);
`ifdef UART_RX_BREAK_DET_EN
                    parbit_d = vote;
`endif
                end
                if (wrap) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (at_vote) begin
                    if (!vote) ferr_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    if (is_break) begin
                        state_d = ST_BREAK;
                        cnt_d   = '0;
                        brk_d   = 1'b1;
                    end else
`endif
                    if (bit_q == STOP_LAST) begin
                        // Leave mid-bit so a start edge right after the stop bit is caught.
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (wrap) begin
                    bit_d = bit_q + 4'd1;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BREAK: begin
                // cnt counts consecutive high cycles; one full bit period of idle re-arms.
                if (!rx_sync_q) begin
                    cnt_d = '0;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    brk_d   = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            if (!valid_q || uart_ready) begin
                data_d  = shift_q;
                operr_d = perr_q;
                oferr_d = ferr_q | ~vote;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && uart_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            operr_q   <= 1'b0;
            oferr_q   <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            parbit_q  <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            operr_q   <= operr_d;
            oferr_q   <= oferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            parbit_q  <= parbit_d;
            brk_q     <= brk_d;
`endif
        end
    end

    assign uart_data  = data_q;
    assign uart_valid = valid_q;
    assign parity_err = operr_q;
    assign frame_err  = oferr_q;
    assign overrun    = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 7E1, 8O2) at 10 clocks per bit, each on its
// own serial line. Frames are built from data/parity/stop rules and results are compared
// against expectations computed here.
module tb_uart_rx_param;

    localparam int BPS = 10;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] rxd = 3'b111;
    logic       rdy = 1'b1;
    int         cyc = 0;

    logic [7:0] dat0, dat2;
    logic [6:0] dat1;
    logic       val0, val1, val2, pe0, pe1, pe2, fe0, fe1, fe2, ovr0, ovr1, ovr2;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk0, brk1, brk2;
    logic       brk_seen = 1'b0;
`endif

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } rec_t;

    rec_t rxq[$];
    int   ovr_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   c_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[0]), .uart_data(dat0), .uart_valid(val0),
        .uart_ready(rdy), .parity_err(pe0), .frame_err(fe0), .overrun(ovr0)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk0)
`endif
    );
    uart_rx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[1]), .uart_data(dat1), .uart_valid(val1),
        .uart_ready(rdy), .parity_err(pe1), .frame_err(fe1), .overrun(ovr1)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk1)
`endif
    );
    uart_rx_param #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
        .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[2]), .uart_data(dat2), .uart_valid(val2),
        .uart_ready(rdy), .parity_err(pe2), .frame_err(fe2), .overrun(ovr2)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk2)
`endif
    );

    // Transfer monitor: every valid && ready cycle is one delivered word.
    always @(negedge clk) begin
        rec_t r;
        if (!sys_rst) begin
            if (val0 && rdy) begin r.k = 0; r.d = {1'b0, dat0}; r.pe = pe0; r.fe = fe0; r.cyc = cyc; rxq.push_back(r); end
            if (val1 && rdy) begin r.k = 1; r.d = {2'b0, dat1}; r.pe = pe1; r.fe = fe1; r.cyc = cyc; rxq.push_back(r); end
            if (val2 && rdy) begin r.k = 2; r.d = {1'b0, dat2}; r.pe = pe2; r.fe = fe2; r.cyc = cyc; rxq.push_back(r); end
            ovr_cnt = ovr_cnt + int'(ovr0) + int'(ovr1) + int'(ovr2);
`ifdef UART_RX_BREAK_DET_EN
            if (brk0 || brk1 || brk2) brk_seen = 1'b1;
`endif
        end
    end

    // Receiver configurations
    function automatic int db(input int k); return (k == 1) ? 7 : 8; endfunction
    function automatic int pm(input int k); return (k == 0) ? 0 : ((k == 1) ? 2 : 1); endfunction
    function automatic int sb(input int k); return (k == 2) ? 2 : 1; endfunction

    // Parity bit that makes the total number of ones even (mode 2) or odd (mode 1).
    function automatic logic par_of(input int k, input logic [8:0] d);
        int ones;
        ones = $countones(d);
        if (pm(k) == 1) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n bits, LSB first, each BPS clocks; optionally pulse reset mid bit rst_at.
    task automatic send_bits(input int k, input int n, input logic [15:0] v, input int rst_at);
        for (int i = 0; i < n; i++) begin
            rxd[k] = v[i];
            for (int c = 0; c < BPS; c++) begin
                sys_rst = (i == rst_at) && (c == 5);
                @(posedge clk);
                #1;
            end
        end
        sys_rst = 1'b0;
        rxd[k]  = 1'b1;
    endtask

    task automatic send_frame(input int k, input logic [8:0] d, input bit pflip, input bit serr, input int rst_at);
        logic [15:0] v;
        int n;
        v = '1;
        n = 0;
        v[n] = 1'b0; n++;
        for (int i = 0; i < db(k); i++) begin v[n] = d[i]; n++; end
        if (pm(k) != 0) begin v[n] = par_of(k, d) ^ pflip; n++; end
        for (int s = 0; s < sb(k); s++) begin v[n] = !(serr && (s == sb(k) - 1)); n++; end
        @(posedge clk);
        #1;
        c_start = cyc;
        send_bits(k, n, v, rst_at);
    endtask

    task automatic expect_rx(input string tag, input int k, input logic [8:0] d, input logic pe, input logic fe);
        rec_t r;
        for (int i = 0; i < 400 && rxq.size() == 0; i++) @(posedge clk);
        #1;
        check({tag, "_count"}, rxq.size(), 1);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            check({tag, "_inst"}, r.k, k);
            check({tag, "_data"}, r.d, d);
            check({tag, "_perr"}, r.pe, pe);
            check({tag, "_ferr"}, r.fe, fe);
        end
        rxq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        bit         pf, se;
        rec_t       r;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        check("rst_valid0", val0, 0);
        check("rst_data0", dat0, 0);
        check("rst_perr0", pe0, 0);
        check("rst_ferr0", fe0, 0);
        check("rst_ovr0", ovr0, 0);
        check("rst_valid12", {val1, val2}, 0);
        idle(20);

        // 8N1 0xA5 with latency: last stop is bit 9, word appears 10*(9+1) clocks after the start edge
        send_frame(0, 9'h0A5, 0, 0, -1);
        idle(15);
        check("a5_count", rxq.size(), 1);
        if (rxq.size() > 0) check("a5_latency", rxq[0].cyc - c_start, 100);
        expect_rx("a5", 0, 9'h0A5, 0, 0);
        check("a5_valid_clear", val0, 0);

        // 7E1: wrong parity bit, then correct parity bit
        send_frame(1, 9'h041, 1, 0, -1);
        idle(15);
        expect_rx("par_bad", 1, 9'h041, 1, 0);
        send_frame(1, 9'h041, 0, 0, -1);
        idle(15);
        expect_rx("par_ok", 1, 9'h041, 0, 0);

        // Two stop bits, second one low
        send_frame(2, 9'h03C, 0, 1, -1);
        idle(15);
        expect_rx("stop2", 2, 9'h03C, 0, 1);

        // 3-cycle glitch on the idle line, then a good frame
        rxd[0] = 1'b0;
        idle(3);
        rxd[0] = 1'b1;
        idle(40);
        check("glitch_none", rxq.size(), 0);
        send_frame(0, 9'h05A, 0, 0, -1);
        idle(15);
        expect_rx("after_glitch", 0, 9'h05A, 0, 0);

        // Overrun: consumer stalled across two back-to-back frames
        check("ovr_none_yet", ovr_cnt, 0);
        rdy = 1'b0;
        send_frame(0, 9'h011, 0, 0, -1);
        send_frame(0, 9'h022, 0, 0, -1);
        idle(20);
        check("ovr_pulse", ovr_cnt, 1);
        check("ovr_hold_valid", val0, 1);
        check("ovr_hold_data", dat0, 8'h11);
        check("ovr_nothing_xfer", rxq.size(), 0);
        rdy = 1'b1;
        idle(10);
        expect_rx("ovr_xfer", 0, 9'h011, 0, 0);
        check("ovr_valid_clear", val0, 0);
        check("ovr_pulse_once", ovr_cnt, 1);

        // Reset in the middle of data bit 4 (frame bit index 5)
        send_frame(0, 9'h0FF, 0, 0, 5);
        idle(30);
        check("rst_mid_none", rxq.size(), 0);
        check("rst_mid_valid", val0, 0);
        send_frame(0, 9'h081, 0, 0, -1);
        idle(15);
        expect_rx("after_rst", 0, 9'h081, 0, 0);

`ifdef UART_RX_BREAK_DET_EN
        // Twelve bit-times of low line
        brk_seen = 1'b0;
        rxd[0] = 1'b0;
        idle(12 * BPS);
        rxd[0] = 1'b1;
        check("brk_seen", brk_seen, 1);
        check("brk_held", brk0, 1);
        idle(25);
        check("brk_cleared", brk0, 0);
        check("brk_no_data", rxq.size(), 0);
        check("brk_no_ovr", ovr_cnt, 1);
        send_frame(0, 9'h0C3, 0, 0, -1);
        idle(15);
        expect_rx("after_brk", 0, 9'h0C3, 0, 0);
`endif

        // Randomized frames on every receiver format
        for (int k = 0; k < 3; k++) begin
            for (int f = 0; f < 6; f++) begin
                d  = 9'($urandom) & 9'((1 << db(k)) - 1);
                pf = (pm(k) != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
                se = ($urandom_range(0, 2) == 0);
                if (se && d == 9'h0) d = 9'h001;
                send_frame(k, d, pf, se, -1);
                idle(20);
                expect_rx($sformatf("rand_k%0d_f%0d", k, f), k, d, pf, se);
            end
        end
        check("rand_no_ovr", ovr_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
